// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with an N-channel priority bypass
// network, internal load-use hazard detection and valid/ready back-pressure.
module id_ex_stage #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 24,
    parameter int NFWD   = 3,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [31:0]          in_instr,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [4:0]           in_rs1_idx,
    input  logic [4:0]           in_rs2_idx,
    input  logic [4:0]           in_rd_idx,
    input  logic                 in_need_rs1,
    input  logic                 in_need_rs2,
    input  logic [XLEN-1:0]      in_rs1_data,
    input  logic [XLEN-1:0]      in_rs2_data,
    input  logic [NFWD-1:0]      fwd_en,
    input  logic [NFWD-1:0]      fwd_pending,
    input  logic [5*NFWD-1:0]    fwd_idx,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [31:0]          out_instr,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_rs1_data,
    output logic [XLEN-1:0]      out_rs2_data,
    output logic [4:0]           out_rd_idx,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic              w_hit1, w_hit2;
    logic              w_pend1, w_pend2;
    logic [XLEN-1:0]   w_fwd1, w_fwd2;
    logic [XLEN-1:0]   w_op1, w_op2;
    logic              w_hazard;
    logic              w_accept;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_instr;
    logic [CTRL_W-1:0] r_ctrl;
    logic [XLEN-1:0]   r_imm;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;
    logic [4:0]        r_rd;
    logic [CNT_W-1:0]  r_stall_cnt;

    // Scan from lowest priority up so the youngest matching channel wins.
    always_comb begin
        w_hit1  = 1'b0;
        w_pend1 = 1'b0;
        w_fwd1  = '0;
        w_hit2  = 1'b0;
        w_pend2 = 1'b0;
        w_fwd2  = '0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (fwd_en[k] && fwd_idx[5*k +: 5] == in_rs1_idx) begin
                w_hit1  = 1'b1;
                w_pend1 = fwd_pending[k];
                w_fwd1  = fwd_data[XLEN*k +: XLEN];
            end
            if (fwd_en[k] && fwd_idx[5*k +: 5] == in_rs2_idx) begin
                w_hit2  = 1'b1;
                w_pend2 = fwd_pending[k];
                w_fwd2  = fwd_data[XLEN*k +: XLEN];
            end
        end
        if (in_rs1_idx == 5'd0) begin
            w_hit1  = 1'b0;
            w_pend1 = 1'b0;
        end
        if (in_rs2_idx == 5'd0) begin
            w_hit2  = 1'b0;
            w_pend2 = 1'b0;
        end
    end

    assign w_op1 = (in_rs1_idx == 5'd0) ? '0 :
                   w_hit1 ? w_fwd1 : in_rs1_data;
    assign w_op2 = (in_rs2_idx == 5'd0) ? '0 :
                   w_hit2 ? w_fwd2 : in_rs2_data;

    assign w_hazard = in_valid &
                      ((in_need_rs1 & w_hit1 & w_pend1) |
                       (in_need_rs2 & w_hit2 & w_pend2));

    assign in_ready = (!r_valid || out_ready) && !w_hazard && !flush;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_instr     <= '0;
            r_ctrl      <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_pc    <= in_pc;
                r_instr <= in_instr;
                r_ctrl  <= in_ctrl;
                r_imm   <= in_imm;
                r_rs1   <= w_op1;
                r_rs2   <= w_op2;
                r_rd    <= in_rd_idx;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            // Saturate rather than wrap so long stalls stay visible.
            if (w_hazard && !flush && r_stall_cnt != {CNT_W{1'b1}})
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_instr    = r_instr;
    assign out_ctrl     = r_ctrl;
    assign out_imm      = r_imm;
    assign out_rs1_data = r_rs1;
    assign out_rs2_data = r_rs2;
    assign out_rd_idx   = r_rd;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against a transaction-level model of the stage.
module tb_id_ex_stage;
    localparam int XLEN   = 64;
    localparam int CTRL_W = 24;
    localparam int NFWD   = 3;
    localparam int CNT_W  = 2;
    localparam int CMAX   = 3;

    logic                 clk = 1'b0;
    logic                 rstn, flush, in_valid, in_ready;
    logic [XLEN-1:0]      in_pc, in_imm, in_rs1_data, in_rs2_data;
    logic [31:0]          in_instr;
    logic [CTRL_W-1:0]    in_ctrl;
    logic [4:0]           in_rs1_idx, in_rs2_idx, in_rd_idx;
    logic                 in_need_rs1, in_need_rs2;
    logic [NFWD-1:0]      fwd_en, fwd_pending;
    logic [5*NFWD-1:0]    fwd_idx;
    logic [XLEN*NFWD-1:0] fwd_data;
    logic                 out_valid, out_ready;
    logic [XLEN-1:0]      out_pc, out_imm, out_rs1_data, out_rs2_data;
    logic [31:0]          out_instr;
    logic [CTRL_W-1:0]    out_ctrl;
    logic [4:0]           out_rd_idx;
    logic [CNT_W-1:0]     stall_cnt;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_ctrl(in_ctrl), .in_imm(in_imm),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx),
        .in_need_rs1(in_need_rs1), .in_need_rs2(in_need_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .fwd_en(fwd_en), .fwd_pending(fwd_pending),
        .fwd_idx(fwd_idx), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_ctrl(out_ctrl),
        .out_imm(out_imm), .out_rs1_data(out_rs1_data),
        .out_rs2_data(out_rs2_data), .out_rd_idx(out_rd_idx),
        .stall_cnt(stall_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Expected contents of the stage after each clock edge
    logic            m_valid;
    logic [XLEN-1:0] m_pc, m_imm, m_rs1, m_rs2;
    logic [31:0]     m_instr;
    logic [CTRL_W-1:0] m_ctrl;
    logic [4:0]      m_rd;
    int              m_cnt;
    logic            m_dc1, m_dc2;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Youngest channel holding idx, -1 if none (x0 never matches).
    function automatic int find_ch(logic [4:0] idx);
        if (idx == 5'd0) return -1;
        for (int k = 0; k < NFWD; k++)
            if (fwd_en[k] && fwd_idx[5*k +: 5] == idx) return k;
        return -1;
    endfunction

    function automatic logic is_pend(logic [4:0] idx);
        int k;
        k = find_ch(idx);
        return (k >= 0) ? fwd_pending[k] : 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] operand(logic [4:0] idx, logic [XLEN-1:0] rf);
        int k;
        if (idx == 5'd0) return '0;
        k = find_ch(idx);
        return (k >= 0) ? fwd_data[XLEN*k +: XLEN] : rf;
    endfunction

    task automatic cycle();
        logic hz, rdy;
        #1;
        hz  = in_valid && ((in_need_rs1 && is_pend(in_rs1_idx)) ||
                           (in_need_rs2 && is_pend(in_rs2_idx)));
        rdy = (!m_valid || out_ready) && !hz && !flush;
        if (rstn) chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
        if (!rstn) begin
            m_valid = 0; m_pc = 0; m_instr = 0; m_ctrl = 0; m_imm = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_cnt = 0; m_dc1 = 0; m_dc2 = 0;
        end else begin
            if (hz && !flush && m_cnt < CMAX) m_cnt++;
            if (flush) m_valid = 0;
            else if (in_valid && rdy) begin
                m_valid = 1;
                m_pc = in_pc; m_instr = in_instr; m_ctrl = in_ctrl;
                m_imm = in_imm; m_rd = in_rd_idx;
                m_rs1 = operand(in_rs1_idx, in_rs1_data);
                m_rs2 = operand(in_rs2_idx, in_rs2_data);
                m_dc1 = !in_need_rs1 && is_pend(in_rs1_idx);
                m_dc2 = !in_need_rs2 && is_pend(in_rs2_idx);
            end else if (out_ready) m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        chk("out_pc", out_pc, m_pc);
        chk("out_instr", {32'd0, out_instr}, {32'd0, m_instr});
        chk("out_ctrl", {40'd0, out_ctrl}, {40'd0, m_ctrl});
        chk("out_imm", out_imm, m_imm);
        chk("out_rd", {59'd0, out_rd_idx}, {59'd0, m_rd});
        chk("stall_cnt", {62'd0, stall_cnt}, 64'(m_cnt));
        if (!m_dc1) chk("out_rs1", out_rs1_data, m_rs1);
        if (!m_dc2) chk("out_rs2", out_rs2_data, m_rs2);
    endtask

    task automatic idle();
        rstn = 1; flush = 0; in_valid = 0; out_ready = 1;
        in_need_rs1 = 0; in_need_rs2 = 0;
        fwd_en = 0; fwd_pending = 0; fwd_idx = 0; fwd_data = 0;
    endtask

    task automatic put(logic [63:0] pc, logic [4:0] r1, logic [4:0] r2,
                       logic n1, logic n2);
        in_valid = 1; in_pc = pc; in_instr = pc[31:0] ^ 32'h13;
        in_ctrl = pc[23:0] ^ 24'h5A5A5A; in_imm = ~pc;
        in_rs1_idx = r1; in_rs2_idx = r2; in_rd_idx = pc[6:2];
        in_need_rs1 = n1; in_need_rs2 = n2;
        in_rs1_data = 64'h11; in_rs2_data = 64'h99;
    endtask

    task automatic set_ch(int k, logic en, logic pend, logic [4:0] idx,
                          logic [63:0] d);
        fwd_en[k] = en; fwd_pending[k] = pend;
        fwd_idx[5*k +: 5] = idx; fwd_data[XLEN*k +: XLEN] = d;
    endtask

    initial begin
        idle();
        put(64'h0, 5'd0, 5'd0, 0, 0);
        in_valid = 0;
        m_cnt = 0; m_valid = 0;
        rstn = 0;
        cycle();
        cycle();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_cnt", {62'd0, stall_cnt}, 64'd0);

        // back-to-back flow
        idle();
        for (int i = 0; i < 4; i++) begin
            put(64'h8000_0000 + 64'(4 * i), 5'd1, 5'd2, 1, 1);
            cycle();
            chk("b2b_pc", out_pc, 64'h8000_0000 + 64'(4 * i));
            chk("b2b_valid", {63'd0, out_valid}, 64'd1);
        end
        idle();
        cycle();
        chk("b2b_drain", {63'd0, out_valid}, 64'd0);

        // bypass priority
        put(64'h1000, 5'd5, 5'd0, 1, 0);
        set_ch(0, 1, 0, 5'd5, 64'hAA);
        set_ch(2, 1, 0, 5'd5, 64'hCC);
        cycle();
        chk("byp_ch0", out_rs1_data, 64'hAA);
        set_ch(0, 0, 0, 5'd5, 64'hAA);
        cycle();
        chk("byp_ch2", out_rs1_data, 64'hCC);
        put(64'h1008, 5'd0, 5'd0, 1, 0);
        set_ch(0, 1, 0, 5'd0, 64'hAA);
        cycle();
        chk("byp_x0", out_rs1_data, 64'h0);

        // load-use stall, flush during hazard, then release
        idle();
        put(64'h2000, 5'd0, 5'd7, 0, 1);
        set_ch(0, 1, 1, 5'd7, 64'hDEAD);
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("lu_ready", {63'd0, in_ready}, 64'd0);
            chk("lu_bubble", {63'd0, out_valid}, 64'd0);
        end
        chk("lu_cnt", {62'd0, stall_cnt}, 64'd2);
        flush = 1;
        cycle();
        chk("lu_flush_cnt", {62'd0, stall_cnt}, 64'd2);
        chk("lu_flush_valid", {63'd0, out_valid}, 64'd0);
        flush = 0;
        set_ch(0, 1, 0, 5'd7, 64'h1234);
        cycle();
        chk("lu_accept", {63'd0, out_valid}, 64'd1);
        chk("lu_rs2", out_rs2_data, 64'h1234);

        // shadowed pending and unused operand
        set_ch(0, 1, 0, 5'd7, 64'h55);
        set_ch(1, 1, 1, 5'd7, 64'h77);
        put(64'h3000, 5'd0, 5'd7, 0, 1);
        cycle();
        chk("shadow_rs2", out_rs2_data, 64'h55);
        chk("shadow_cnt", {62'd0, stall_cnt}, 64'd2);
        set_ch(1, 0, 0, 5'd0, 64'h0);
        set_ch(0, 1, 1, 5'd7, 64'h0);
        put(64'h3004, 5'd7, 5'd3, 0, 1);
        cycle();
        chk("unused_valid", {63'd0, out_valid}, 64'd1);
        chk("unused_pc", out_pc, 64'h3004);

        // back-pressure then flush
        idle();
        put(64'h100, 5'd1, 5'd2, 1, 1);
        cycle();
        out_ready = 0;
        put(64'h200, 5'd1, 5'd2, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_pc", out_pc, 64'h100);
            chk("bp_ready", {63'd0, in_ready}, 64'd0);
        end
        flush = 1;
        cycle();
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_pc", out_pc, 64'h100);
        idle();
        cycle();
        chk("fl_after", {63'd0, out_valid}, 64'd0);

        // saturation then reset mid-stall
        rstn = 0;
        cycle();
        idle();
        put(64'h4000, 5'd9, 5'd0, 1, 0);
        set_ch(1, 1, 1, 5'd9, 64'h0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("sat_cnt", {62'd0, stall_cnt}, 64'((i < 3) ? i + 1 : 3));
        end
        rstn = 0;
        cycle();
        chk("rst2_cnt", {62'd0, stall_cnt}, 64'd0);
        chk("rst2_valid", {63'd0, out_valid}, 64'd0);
        chk("rst2_pc", out_pc, 64'd0);
        chk("rst2_rs1", out_rs1_data, 64'd0);

        // randomized traffic
        idle();
        for (int i = 0; i < 400; i++) begin
            rstn        = ($urandom_range(0, 99) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            out_ready   = ($urandom_range(0, 9) < 7);
            in_valid    = ($urandom_range(0, 9) < 8);
            in_pc       = {$urandom, $urandom};
            in_instr    = $urandom;
            in_ctrl     = 24'($urandom);
            in_imm      = {$urandom, $urandom};
            in_rs1_idx  = 5'($urandom_range(0, 7));
            in_rs2_idx  = 5'($urandom_range(0, 7));
            in_rd_idx   = 5'($urandom);
            in_need_rs1 = 1'($urandom);
            in_need_rs2 = 1'($urandom);
            in_rs1_data = {$urandom, $urandom};
            in_rs2_data = {$urandom, $urandom};
            for (int k = 0; k < NFWD; k++)
                set_ch(k, 1'($urandom), ($urandom_range(0, 3) == 0),
                       5'($urandom_range(0, 7)), {$urandom, $urandom});
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
